// File: rtl/wddl_pkg.sv
// Shared types and helpers for the WDDL dual-rail sequencer: FSM state
// encoding, the dual-rail pair type, and the per-bit encode/validity rules.
package wddl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_EVAL = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // One WDDL signal: a true rail and a false rail. 00 is the precharged
  // (spacer) value, 10/01 carry a logic 1/0, and 11 is never legal.
  typedef struct packed {
    logic t;
    logic f;
  } dr_pair_t;

  // Single-rail bit to its evaluate-phase dual-rail code.
  function automatic dr_pair_t encode(input logic d);
    dr_pair_t p;
    p.t = d;
    p.f = ~d;
    return p;
  endfunction

  // A returned pair is a valid data code only when exactly one rail is high.
  function automatic logic pair_valid(input dr_pair_t p);
    return p.t ^ p.f;
  endfunction

endpackage

// File: rtl/wddl_dr_check.sv
// Combinational decode of a returned dual-rail word: the single-rail value is
// the true rails, and err_o flags any bit that is spacer (00) or illegal (11).
// Only instantiated when WDDL_RAIL_CHECK_EN is defined.
module wddl_dr_check
  import wddl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] ret_t_i,
  input  logic [WIDTH-1:0] ret_f_i,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o
);

  logic [WIDTH-1:0] bit_ok;

  // Per-bit rail-code validity.
  always_comb begin
    bit_ok = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bit_ok[i] = pair_valid(dr_pair_t'({ret_t_i[i], ret_f_i[i]}));
    end
  end

  assign data_o = ret_t_i;
  assign err_o  = ~(&bit_ok);

endmodule

// File: rtl/wddl_dr_seq.sv
// Sequencer/encoder/decoder for the far side of a WDDL dual-rail cone.
// Each accepted word runs IDLE -> PRE -> EVAL -> HOLD -> IDLE: the cone is
// precharged, driven with the dual-rail code of the word for EVAL_CYC cycles,
// the returned true rails are captured, and the result is held until the
// consumer takes it.
// Optional feature: define WDDL_RAIL_CHECK_EN to check the returned rail codes
// at capture and report bad codes on err_o; otherwise err_o is tied low.
module wddl_dr_seq
  import wddl_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRE_CYC  = 1,
  parameter int EVAL_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             prechrg_o,
  output logic [WIDTH-1:0] t_o,
  output logic [WIDTH-1:0] f_o,
  input  logic [WIDTH-1:0] ret_t_i,
  input  logic [WIDTH-1:0] ret_f_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             err_o
);

  localparam int MAX_CYC = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(EVAL_CYC - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] data_q;
  logic             load, capture, release_res;
  logic             prechrg_n;
  logic [WIDTH-1:0] t_n, f_n;
  logic [WIDTH-1:0] dec_data;
  dr_pair_t         pair;

  assign in_ready_o = (state == ST_IDLE);

  // Next-state, phase counter and next registered rail/precharge values.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    load        = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    prechrg_n   = 1'b1;
    t_n         = '0;
    f_n         = '0;
    pair        = '0;

    unique case (state)
      ST_IDLE: begin
        if (in_valid_i) begin
          load    = 1'b1;
          cnt_n   = '0;
          state_n = ST_PRE;
        end
      end
      ST_PRE: begin
        if (cnt == PRE_LAST) begin
          cnt_n   = '0;
          state_n = ST_EVAL;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        if (cnt == EVAL_LAST) begin
          cnt_n   = '0;
          capture = 1'b1;
          state_n = ST_HOLD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready_i) begin
          release_res = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Rails follow the state being entered so they are registered together
    // with it; outside EVAL the cone is held in precharge with rails at 00.
    if (state_n == ST_EVAL) begin
      prechrg_n = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        pair   = encode(data_q[i]);
        t_n[i] = pair.t;
        f_n[i] = pair.f;
      end
    end
  end

  // State, counter, drive rails and result registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of statement order.
    if (rst_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      prechrg_o   <= 1'b1;
      t_o         <= '0;
      f_o         <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      prechrg_o <= prechrg_n;
      t_o       <= t_n;
      f_o       <= f_n;
      if (capture) begin
        out_valid_o <= 1'b1;
        out_data_o  <= dec_data;
      end else if (release_res) begin
        out_valid_o <= 1'b0;
      end
    end
  end

  // Accepted word, only read while driving EVAL.
  always_ff @(posedge clk_i) begin
    // NOTE: this is a pure datapath register qualified by the FSM, so it is
    // deliberately left without reset.
    if (load) begin
      data_q <= in_data_i;
    end
  end

`ifdef WDDL_RAIL_CHECK_EN
  logic check_err;

  wddl_dr_check #(
    .WIDTH (WIDTH)
  ) u_check (
    .ret_t_i (ret_t_i),
    .ret_f_i (ret_f_i),
    .data_o  (dec_data),
    .err_o   (check_err)
  );

  // Rail-code error captured alongside the data, cleared on handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (capture) begin
      err_o <= check_err;
    end else if (release_res) begin
      err_o <= 1'b0;
    end
  end
`else
  // Without the check the false rails carry no information we use.
  logic unused_ret_f;

  assign dec_data     = ret_t_i;
  assign err_o        = 1'b0;
  assign unused_ret_f = ^ret_f_i;
`endif

endmodule
